// File: rtl/tis_pkg.sv
// Shared types, widths and helpers for the tis_core execution node.
package tis_pkg;

    localparam int W     = 11;
    localparam int NPROG = 15;
    localparam int MAXV  = 999;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_MOV = 4'd1,
        OP_SWP = 4'd2,
        OP_SAV = 4'd3,
        OP_ADD = 4'd4,
        OP_SUB = 4'd5,
        OP_NEG = 4'd6,
        OP_JMP = 4'd7,
        OP_JEZ = 4'd8,
        OP_JNZ = 4'd9,
        OP_JGZ = 4'd10,
        OP_JLZ = 4'd11,
        OP_JRO = 4'd12
    } op_e;

    typedef enum logic [2:0] {
        LOC_NIL   = 3'd0,
        LOC_ACC   = 3'd1,
        LOC_LEFT  = 3'd2,
        LOC_RIGHT = 3'd3,
        LOC_UP    = 3'd4,
        LOC_DOWN  = 3'd5
    } loc_e;

    typedef enum logic {EXEC, WRITE} state_e;

    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_NEG} alu_op_e;

    localparam logic signed [W+1:0] MAXV_X = MAXV;

    function automatic logic signed [W-1:0] saturate(input logic signed [W+1:0] v);
        if (v > MAXV_X) return MAXV_X[W-1:0];
        if (v < -MAXV_X) return -MAXV_X[W-1:0];
        return v[W-1:0];
    endfunction

endpackage

// File: rtl/tis_alu.sv
// Saturating add/sub/neg on the node's signed data width.
module tis_alu
    import tis_pkg::*;
(
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    input  alu_op_e             op_i,
    output logic signed [W-1:0] y_o
);

    logic signed [W+1:0] a_x, b_x, raw;

    assign a_x = {{2{a_i[W-1]}}, a_i};
    assign b_x = {{2{b_i[W-1]}}, b_i};

    always_comb begin
        raw = a_x + b_x;
        unique case (op_i)
            ALU_SUB: raw = a_x - b_x;
            ALU_NEG: raw = -a_x;
            default: raw = a_x + b_x;
        endcase
    end

    assign y_o = saturate(raw);

endmodule

// File: rtl/tis_core.sv
// One TIS-100-style node: fetch/execute with ACC/BAK and four
// blocking neighbour ports.
module tis_core
    import tis_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          pLength,
    input  logic [15:0]         prog [0:NPROG-1],
    output logic signed [W-1:0] acc,
    input  logic signed [W-1:0] left,
    input  logic signed [W-1:0] right,
    input  logic signed [W-1:0] up,
    input  logic signed [W-1:0] down,
    input  logic                rreadyL,
    input  logic                rreadyR,
    input  logic                rreadyU,
    input  logic                rreadyD,
    output logic                rackL,
    output logic                rackR,
    output logic                rackU,
    output logic                rackD,
    output logic                wvalidL,
    output logic                wvalidR,
    output logic                wvalidU,
    output logic                wvalidD,
    input  logic                wackL,
    input  logic                wackR,
    input  logic                wackU,
    input  logic                wackD,
    output logic signed [W-1:0] outval
);

    state_e              state_q, state_d;
    logic [3:0]          pc_q, pc_d;
    logic signed [W-1:0] acc_q, acc_d;
    logic signed [W-1:0] bak_q, bak_d;
    logic signed [W-1:0] out_q, out_d;
    logic [1:0]          wdst_q, wdst_d;

    logic [15:0]         instr;
    logic                is_movi, is_immf, uses_src, src_port, stall;
    logic [3:0]          rop, rdy, wack, rack_c, adv, jtgt;
    logic [2:0]          src_code, dst_code;
    logic [1:0]          src_idx;
    logic signed [W-1:0] imm, src_val, operand, alu_y, mov_val;
    logic signed [W+1:0] jro_sum, plen_m1;
    logic [4:0]          pc_inc;
    alu_op_e             alu_op;
    logic                do_mov;

    assign rdy  = {rreadyD, rreadyU, rreadyR, rreadyL};
    assign wack = {wackD, wackU, wackR, wackL};

    assign instr    = (pc_q < 4'(NPROG)) ? prog[pc_q] : 16'h0;
    assign is_movi  = instr[15];
    assign is_immf  = (instr[15:14] == 2'b01);
    assign rop      = instr[13:10];
    assign imm      = instr[10:0];
    assign src_code = (is_movi || is_immf) ? LOC_NIL : instr[9:7];
    assign dst_code = is_movi ? instr[14:12] : instr[6:4];
    assign uses_src = !is_movi && !is_immf
                   && (rop == OP_MOV || rop == OP_ADD
                    || rop == OP_SUB || rop == OP_JRO);
    assign src_port = (src_code >= LOC_LEFT) && (src_code <= LOC_DOWN);
    assign src_idx  = 2'(src_code - LOC_LEFT);
    assign stall    = uses_src && src_port && !rdy[src_idx];

    always_comb begin
        src_val = '0;
        unique case (src_code)
            LOC_ACC:   src_val = acc_q;
            LOC_LEFT:  src_val = left;
            LOC_RIGHT: src_val = right;
            LOC_UP:    src_val = up;
            LOC_DOWN:  src_val = down;
            default:   src_val = '0;
        endcase
    end

    assign operand = (is_movi || is_immf) ? imm : src_val;
    assign mov_val = saturate({{2{operand[W-1]}}, operand});

    always_comb begin
        alu_op = ALU_ADD;
        if (is_immf) begin
            if (instr[13:12] == 2'b01) alu_op = ALU_SUB;
        end else if (rop == OP_SUB) begin
            alu_op = ALU_SUB;
        end else if (rop == OP_NEG) begin
            alu_op = ALU_NEG;
        end
    end

    tis_alu u_alu (
        .a_i  (acc_q),
        .b_i  (operand),
        .op_i (alu_op),
        .y_o  (alu_y)
    );

    assign pc_inc  = {1'b0, pc_q} + 5'd1;
    assign adv     = (pc_inc >= {1'b0, pLength}) ? 4'd0 : pc_inc[3:0];
    assign jtgt    = (instr[3:0] >= pLength) ? 4'd0 : instr[3:0];
    assign jro_sum = $signed({{(W-2){1'b0}}, pc_q})
                   + {{2{operand[W-1]}}, operand};
    assign plen_m1 = $signed({{(W-2){1'b0}}, pLength}) - 1;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        bak_d   = bak_q;
        out_d   = out_q;
        wdst_d  = wdst_q;
        rack_c  = '0;
        do_mov  = 1'b0;
        if (state_q == WRITE) begin
            if (wack[wdst_q]) begin
                state_d = EXEC;
                pc_d    = adv;
            end
        end else if (pLength != 4'd0 && !stall) begin
            if (uses_src && src_port) rack_c[src_idx] = 1'b1;
            pc_d = adv;
            unique case (1'b1)
                is_movi: do_mov = 1'b1;
                is_immf: begin
                    unique case (instr[13:12])
                        2'b00, 2'b01: acc_d = alu_y;
                        2'b10: begin
                            if (jro_sum < 0) pc_d = 4'd0;
                            else if (jro_sum > plen_m1) pc_d = plen_m1[3:0];
                            else pc_d = jro_sum[3:0];
                        end
                        default: ;
                    endcase
                end
                default: begin
                    unique case (rop)
                        OP_MOV: do_mov = 1'b1;
                        OP_SWP: begin
                            acc_d = bak_q;
                            bak_d = acc_q;
                        end
                        OP_SAV: bak_d = acc_q;
                        OP_ADD, OP_SUB, OP_NEG: acc_d = alu_y;
                        OP_JMP: pc_d = jtgt;
                        OP_JEZ: if (acc_q == 0) pc_d = jtgt;
                        OP_JNZ: if (acc_q != 0) pc_d = jtgt;
                        OP_JGZ: if (acc_q > 0) pc_d = jtgt;
                        OP_JLZ: if (acc_q < 0) pc_d = jtgt;
                        OP_JRO: begin
                            if (jro_sum < 0) pc_d = 4'd0;
                            else if (jro_sum > plen_m1) pc_d = plen_m1[3:0];
                            else pc_d = jro_sum[3:0];
                        end
                        default: ;
                    endcase
                end
            endcase
            // A port destination parks the value and holds pc until acked.
            if (do_mov) begin
                if (dst_code == LOC_ACC) begin
                    acc_d = mov_val;
                end else if (dst_code >= LOC_LEFT && dst_code <= LOC_DOWN) begin
                    state_d = WRITE;
                    out_d   = mov_val;
                    wdst_d  = 2'(dst_code - LOC_LEFT);
                    pc_d    = pc_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EXEC;
            pc_q    <= '0;
            acc_q   <= '0;
            bak_q   <= '0;
            out_q   <= '0;
            wdst_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            bak_q   <= bak_d;
            out_q   <= out_d;
            wdst_q  <= wdst_d;
        end
    end

    assign {rackD, rackU, rackR, rackL} = rst ? 4'b0 : rack_c;

    assign wvalidL = (state_q == WRITE) && (wdst_q == 2'd0);
    assign wvalidR = (state_q == WRITE) && (wdst_q == 2'd1);
    assign wvalidU = (state_q == WRITE) && (wdst_q == 2'd2);
    assign wvalidD = (state_q == WRITE) && (wdst_q == 2'd3);

    assign acc    = acc_q;
    assign outval = out_q;

endmodule

// File: tb/tb_tis_core.sv
// Scenario-driven bench for tis_core with an ACC scoreboard queue.
module tb_tis_core;
    import tis_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [3:0]          pLength;
    logic [15:0]         prog [0:14];
    logic signed [W-1:0] acc, outval;
    logic signed [W-1:0] left, right, up, down;
    logic rreadyL, rreadyR, rreadyU, rreadyD;
    logic rackL, rackR, rackU, rackD;
    logic wvalidL, wvalidR, wvalidU, wvalidD;
    logic wackL, wackR, wackU, wackD;

    int tests = 0;
    int fails = 0;
    logic signed [W-1:0] exp_q[$];
    logic signed [W-1:0] got, want;

    tis_core dut (
        .clk(clk), .rst(rst), .pLength(pLength), .prog(prog), .acc(acc),
        .left(left), .right(right), .up(up), .down(down),
        .rreadyL(rreadyL), .rreadyR(rreadyR),
        .rreadyU(rreadyU), .rreadyD(rreadyD),
        .rackL(rackL), .rackR(rackR), .rackU(rackU), .rackD(rackD),
        .wvalidL(wvalidL), .wvalidR(wvalidR),
        .wvalidU(wvalidU), .wvalidD(wvalidD),
        .wackL(wackL), .wackR(wackR), .wackU(wackU), .wackD(wackD),
        .outval(outval)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 15; i++) prog[i] = 16'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        left = '0; right = '0; up = '0; down = '0;
        {rreadyL, rreadyR, rreadyU, rreadyD} = 4'b0;
        {wackL, wackR, wackU, wackD} = 4'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_prog();
        prog[0] = 16'h9005;
        pLength = 4'd1;
        do_reset();
        tests++;
        if (acc !== 11'sd0) begin
            fails++;
            $display("FAIL reset_acc: got %0d want 0", acc);
        end
        tests++;
        if ({wvalidL, wvalidR, wvalidU, wvalidD, rackL, rackR, rackU, rackD} !== 8'b0) begin
            fails++;
            $display("FAIL reset_hs: got %b want 00000000",
                {wvalidL, wvalidR, wvalidU, wvalidD, rackL, rackR, rackU, rackD});
        end
        tests++;
        if (outval !== 11'sd0) begin
            fails++;
            $display("FAIL reset_outval: got %0d want 0", outval);
        end
    endtask

    task automatic test_idle();
        clear_prog();
        prog[0] = 16'h9005;
        pLength = 4'd0;
        do_reset();
        repeat (3) step();
        tests++;
        if (acc !== 11'sd0) begin
            fails++;
            $display("FAIL idle_acc: got %0d want 0", acc);
        end
    endtask

    task automatic test_basic();
        int e[6] = '{5, 8, -8, -8, 5, 8};
        clear_prog();
        prog[0] = 16'h9005;
        prog[1] = 16'h4003;
        prog[2] = 16'h1800;
        prog[3] = 16'h1C00;
        pLength = 4'd4;
        do_reset();
        for (int i = 0; i < 6; i++) exp_q.push_back(W'(e[i]));
        for (int i = 0; i < 6; i++) begin
            step();
            got = acc;
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL basic[%0d]: acc=%0d want %0d", i, got, want);
            end
        end
    endtask

    task automatic test_saturate();
        int e[5] = '{990, 999, -990, -999, 990};
        clear_prog();
        prog[0] = 16'h93DE;
        prog[1] = 16'h4014;
        prog[2] = 16'h9422;
        prog[3] = 16'h5014;
        pLength = 4'd4;
        do_reset();
        for (int i = 0; i < 5; i++) exp_q.push_back(W'(e[i]));
        for (int i = 0; i < 5; i++) begin
            step();
            got = acc;
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL sat[%0d]: acc=%0d want %0d", i, got, want);
            end
        end
    endtask

    task automatic test_read_stall();
        clear_prog();
        prog[0] = 16'h9002;
        prog[1] = 16'h1100;
        pLength = 4'd2;
        do_reset();
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            tests++;
            if (acc !== 11'sd2 || rackL !== 1'b0) begin
                fails++;
                $display("FAIL stall[%0d]: acc=%0d rackL=%b want 2/0", i, acc, rackL);
            end
        end
        left = 11'sd1;
        rreadyL = 1'b1;
        #1;
        tests++;
        if ({rackL, rackR, rackU, rackD} !== 4'b1000) begin
            fails++;
            $display("FAIL read_ack: rack=%b want 1000", {rackL, rackR, rackU, rackD});
        end
        step();
        tests++;
        if (acc !== 11'sd3) begin
            fails++;
            $display("FAIL read_acc: got %0d want 3", acc);
        end
        rreadyL = 1'b0;
        #1;
        tests++;
        if (rackL !== 1'b0) begin
            fails++;
            $display("FAIL read_pulse: rackL=%b want 0", rackL);
        end
        step();
        step();
        tests++;
        if (acc !== 11'sd2) begin
            fails++;
            $display("FAIL read_wrap: acc=%0d want 2", acc);
        end
    endtask

    task automatic test_write();
        clear_prog();
        prog[0] = 16'h9007;
        prog[1] = 16'h04B0;
        prog[2] = 16'h4001;
        pLength = 4'd3;
        do_reset();
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            tests++;
            if ({wvalidL, wvalidR, wvalidU, wvalidD} !== 4'b0100
                || outval !== 11'sd7 || acc !== 11'sd7) begin
                fails++;
                $display("FAIL write_hold[%0d]: wvalid=%b outval=%0d acc=%0d want 0100/7/7",
                    i, {wvalidL, wvalidR, wvalidU, wvalidD}, outval, acc);
            end
            wackL = 1'b1;
            step();
        end
        wackL = 1'b0;
        wackR = 1'b1;
        step();
        wackR = 1'b0;
        tests++;
        if ({wvalidL, wvalidR, wvalidU, wvalidD} !== 4'b0000) begin
            fails++;
            $display("FAIL write_drop: wvalid=%b want 0000",
                {wvalidL, wvalidR, wvalidU, wvalidD});
        end
        step();
        tests++;
        if (acc !== 11'sd8) begin
            fails++;
            $display("FAIL write_advance: acc=%0d want 8", acc);
        end
    endtask

    task automatic test_branch();
        int e[8] = '{0, 0, 5, 5, 5, 0, 0, 5};
        clear_prog();
        prog[0] = 16'h9000;
        prog[1] = 16'h2003;
        prog[2] = 16'h9063;
        prog[3] = 16'h9005;
        prog[4] = 16'h2006;
        prog[5] = 16'h280F;
        prog[6] = 16'h9063;
        prog[7] = 16'h9063;
        pLength = 4'd8;
        do_reset();
        for (int i = 0; i < 8; i++) exp_q.push_back(W'(e[i]));
        for (int i = 0; i < 8; i++) begin
            step();
            got = acc;
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL branch[%0d]: acc=%0d want %0d", i, got, want);
            end
        end
    endtask

    task automatic test_jro();
        int e[4] = '{4, 4, 4, 4};
        int f[4] = '{4, 4, 99, 4};
        clear_prog();
        prog[0] = 16'h9004;
        prog[1] = 16'h67FD;
        prog[2] = 16'h9063;
        pLength = 4'd3;
        do_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back(W'(e[i]));
        for (int i = 0; i < 4; i++) begin
            step();
            got = acc;
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL jro_lo[%0d]: acc=%0d want %0d", i, got, want);
            end
        end
        prog[1] = 16'h6009;
        do_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back(W'(f[i]));
        for (int i = 0; i < 4; i++) begin
            step();
            got = acc;
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL jro_hi[%0d]: acc=%0d want %0d", i, got, want);
            end
        end
    endtask

    task automatic test_reset_in_write();
        clear_prog();
        prog[0] = 16'h9007;
        prog[1] = 16'h04B0;
        pLength = 4'd2;
        do_reset();
        step();
        step();
        tests++;
        if (wvalidR !== 1'b1) begin
            fails++;
            $display("FAIL rstw_pre: wvalidR=%b want 1", wvalidR);
        end
        rst = 1'b1;
        step();
        tests++;
        if ({wvalidL, wvalidR, wvalidU, wvalidD} !== 4'b0 || acc !== 11'sd0) begin
            fails++;
            $display("FAIL rstw_abort: wvalid=%b acc=%0d want 0000/0",
                {wvalidL, wvalidR, wvalidU, wvalidD}, acc);
        end
        rst = 1'b0;
        step();
        tests++;
        if (acc !== 11'sd7) begin
            fails++;
            $display("FAIL rstw_restart: acc=%0d want 7", acc);
        end
    endtask

    initial begin
        rst = 1'b1;
        pLength = 4'd0;
        clear_prog();
        test_reset();
        test_idle();
        test_basic();
        test_saturate();
        test_read_stall();
        test_write();
        test_branch();
        test_jro();
        test_reset_in_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
